// File: rtl/cpu_pkg.sv
// Shared encodings for the ARM-subset control sequencer: condition codes, opcodes,
// instruction classes, PC-select values and FSM states.
package cpu_pkg;

  localparam logic [3:0] cond_eq = 4'b0000;
  localparam logic [3:0] cond_ne = 4'b0001;
  localparam logic [3:0] cond_cs = 4'b0010;
  localparam logic [3:0] cond_cc = 4'b0011;
  localparam logic [3:0] cond_mi = 4'b0100;
  localparam logic [3:0] cond_pl = 4'b0101;
  localparam logic [3:0] cond_vs = 4'b0110;
  localparam logic [3:0] cond_vc = 4'b0111;
  localparam logic [3:0] cond_hi = 4'b1000;
  localparam logic [3:0] cond_ls = 4'b1001;
  localparam logic [3:0] cond_ge = 4'b1010;
  localparam logic [3:0] cond_lt = 4'b1011;
  localparam logic [3:0] cond_gt = 4'b1100;
  localparam logic [3:0] cond_le = 4'b1101;
  localparam logic [3:0] cond_al = 4'b1110;
  localparam logic [3:0] cond_nv = 4'b1111;

  localparam logic [3:0] opcode_and = 4'b0000;
  localparam logic [3:0] opcode_eor = 4'b0001;
  localparam logic [3:0] opcode_sub = 4'b0010;
  localparam logic [3:0] opcode_rsb = 4'b0011;
  localparam logic [3:0] opcode_add = 4'b0100;
  localparam logic [3:0] opcode_adc = 4'b0101;
  localparam logic [3:0] opcode_sbc = 4'b0110;
  localparam logic [3:0] opcode_rsc = 4'b0111;
  localparam logic [3:0] opcode_tst = 4'b1000;
  localparam logic [3:0] opcode_teq = 4'b1001;
  localparam logic [3:0] opcode_cmp = 4'b1010;
  localparam logic [3:0] opcode_cmn = 4'b1011;
  localparam logic [3:0] opcode_orr = 4'b1100;
  localparam logic [3:0] opcode_mov = 4'b1101;
  localparam logic [3:0] opcode_bic = 4'b1110;
  localparam logic [3:0] opcode_mvn = 4'b1111;

  localparam logic [1:0] inst_type_data   = 2'b00;
  localparam logic [1:0] inst_type_branch = 2'b10;

  localparam logic [1:0] pc_sel_seq    = 2'd0;
  localparam logic [1:0] pc_sel_branch = 2'd1;
  localparam logic [1:0] pc_sel_alu    = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_t;

  // TST/TEQ/CMP/CMN only update flags and never write Rd.
  function automatic logic is_compare(input logic [3:0] opcode);
    return opcode[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Code-memory handshake plus datapath commit strobes between sequencer (master) and the
// surrounding core (slave).
interface cpu_sequencer_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                fetch_req;
  logic                fetch_ack;
  logic [31:0]         inst;
  logic [3:0]          flags;
  logic                halt_req;
  logic                ir_we;
  logic                rf_we;
  logic                cpsr_we;
  logic                lr_we;
  logic                pc_we;
  logic [1:0]          pc_sel;
  logic                undef;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  fetch_ack, inst, flags, halt_req,
    output fetch_req, ir_we, rf_we, cpsr_we, lr_we, pc_we, pc_sel, undef, halted, retired
  );

  modport slave (
    output fetch_ack, inst, flags, halt_req,
    input  fetch_req, ir_we, rf_we, cpsr_we, lr_we, pc_we, pc_sel, undef, halted, retired
  );
endinterface

// File: rtl/cpu_cond_eval.sv
// ARM condition-code evaluator: cond field against CPSR {N,Z,C,V}.
module cpu_cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;

  always_comb begin
    o_pass = 1'b0;
    unique case (i_cond)
      cond_eq: o_pass = w_z;
      cond_ne: o_pass = !w_z;
      cond_cs: o_pass = w_c;
      cond_cc: o_pass = !w_c;
      cond_mi: o_pass = w_n;
      cond_pl: o_pass = !w_n;
      cond_vs: o_pass = w_v;
      cond_vc: o_pass = !w_v;
      cond_hi: o_pass = w_c && !w_z;
      cond_ls: o_pass = !w_c || w_z;
      cond_ge: o_pass = (w_n == w_v);
      cond_lt: o_pass = (w_n != w_v);
      cond_gt: o_pass = !w_z && (w_n == w_v);
      cond_le: o_pass = w_z || (w_n != w_v);
      cond_al: o_pass = 1'b1;
      cond_nv: o_pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller; the commit decision is made in
// EXECUTE and registered so every strobe is a clean one-cycle pulse in WRITEBACK.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);
  state_t              r_state, w_state_next;
  logic [31:0]         r_ir;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_rf_we, r_cpsr_we, r_lr_we, r_pc_we, r_undef;
  logic [1:0]          r_pc_sel;

  logic       w_fetch_req, w_ir_we, w_pass;
  logic       w_rf_we, w_cpsr_we, w_lr_we, w_pc_we, w_undef;
  logic [1:0] w_pc_sel;
  logic [3:0] w_opcode;
  logic [1:0] w_type;
  logic       w_unused_ir;

  assign w_opcode    = r_ir[24:21];
  assign w_type      = r_ir[27:26];
  assign w_unused_ir = ^{r_ir[25], r_ir[19:16], r_ir[11:0]};

  cpu_cond_eval u_cond_eval (
    .i_cond  (r_ir[31:28]),
    .i_flags (bus.flags),
    .o_pass  (w_pass)
  );

  assign w_fetch_req = (r_state == StFetch);
  assign w_ir_we     = w_fetch_req && bus.fetch_ack;

  always_comb begin
    w_state_next = r_state;
    w_rf_we      = 1'b0;
    w_cpsr_we    = 1'b0;
    w_lr_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_undef      = 1'b0;
    w_pc_sel     = pc_sel_seq;
    unique case (r_state)
      StIdle:   w_state_next = StFetch;
      StFetch:  if (bus.fetch_ack) w_state_next = StDecode;
      StDecode: w_state_next = StExecute;
      StExecute: begin
        w_state_next = StWriteback;
        w_pc_we      = 1'b1;
        if (w_pass) begin
          case (w_type)
            inst_type_branch: begin
              w_pc_sel = pc_sel_branch;
              w_lr_we  = r_ir[24];
            end
            inst_type_data: begin
              if (is_compare(w_opcode)) begin
                w_cpsr_we = 1'b1;
              end else begin
                w_cpsr_we = r_ir[20];
                if (r_ir[15:12] == 4'hf) w_pc_sel = pc_sel_alu;
                else                     w_rf_we  = 1'b1;
              end
            end
            default: w_undef = 1'b1;
          endcase
        end
      end
      StWriteback: w_state_next = bus.halt_req ? StHalt : StFetch;
      StHalt:      if (!bus.halt_req) w_state_next = StFetch;
      default:     w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_ir      <= '0;
      r_retired <= '0;
      r_rf_we   <= 1'b0;
      r_cpsr_we <= 1'b0;
      r_lr_we   <= 1'b0;
      r_pc_we   <= 1'b0;
      r_undef   <= 1'b0;
      r_pc_sel  <= pc_sel_seq;
    end else begin
      r_state   <= w_state_next;
      if (w_ir_we) r_ir <= bus.inst;
      if (r_state == StWriteback) r_retired <= r_retired + RETIRE_W'(1);
      r_rf_we   <= w_rf_we;
      r_cpsr_we <= w_cpsr_we;
      r_lr_we   <= w_lr_we;
      r_pc_we   <= w_pc_we;
      r_undef   <= w_undef;
      r_pc_sel  <= w_pc_sel;
    end
  end

  assign bus.fetch_req = w_fetch_req;
  assign bus.ir_we     = w_ir_we;
  assign bus.rf_we     = r_rf_we;
  assign bus.cpsr_we   = r_cpsr_we;
  assign bus.lr_we     = r_lr_we;
  assign bus.pc_we     = r_pc_we;
  assign bus.pc_sel    = r_pc_sel;
  assign bus.undef     = r_undef;
  assign bus.halted    = (r_state == StHalt);
  assign bus.retired   = r_retired;
endmodule
